// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: 16-bit little-endian word-count header,
// then N little-endian 32-bit words written to imem; holds the core until done.
module imem_loader #(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic              Byte_Valid,
  input  logic [7:0]        Byte_Data,
  output logic              Byte_Ready,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_WData,
  output logic              Core_Hold,
  output logic              Load_Done,
  output logic              Load_Err
);
  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, DONE, ERR} state_t;

  localparam logic [16:0] MEM_WORDS_L = 17'(MEM_WORDS);

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [ADDR_W-1:0]   widx_q, widx_d;
  logic [23:0]         part_q, part_d;
  logic                fin_q, fin_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic        accept;
  logic [15:0] n_w;
  logic        last_word;

  // fin_q marks the final write cycle: stay in DATA with Byte_Ready low so
  // Load_Done rises the cycle after the last Mem_WE pulse.
  assign Byte_Ready = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                      ((state_q == DATA) && !fin_q);
  assign accept     = Byte_Valid && Byte_Ready;
  assign n_w        = {Byte_Data, cnt_q[7:0]};
  assign last_word  = (16'(widx_q) == (cnt_q - 16'd1));

  assign Mem_WE    = we_q;
  assign Mem_Addr  = addr_q;
  assign Mem_WData = wdata_q;
  assign Core_Hold = (state_q != DONE);
  assign Load_Done = (state_q == DONE);
  assign Load_Err  = (state_q == ERR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    widx_d  = widx_q;
    part_d  = part_q;
    fin_d   = fin_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE, ERR: if (Start) state_d = HDR_LO;
      HDR_LO: if (accept) begin
        cnt_d[7:0] = Byte_Data;
        state_d    = HDR_HI;
      end
      HDR_HI: if (accept) begin
        cnt_d[15:8] = Byte_Data;
        bcnt_d      = 2'd0;
        widx_d      = '0;
        part_d      = '0;
        fin_d       = 1'b0;
        if (n_w == 16'd0)                   state_d = DONE;
        else if ({1'b0, n_w} > MEM_WORDS_L) state_d = ERR;
        else                                state_d = DATA;
      end
      DATA: begin
        if (fin_q) begin
          fin_d   = 1'b0;
          state_d = DONE;
        end else if (accept) begin
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: part_d[7:0]   = Byte_Data;
            2'd1: part_d[15:8]  = Byte_Data;
            2'd2: part_d[23:16] = Byte_Data;
            default: begin
              we_d    = 1'b1;
              addr_d  = widx_q;
              wdata_d = {Byte_Data, part_q};
              if (last_word) fin_d  = 1'b1;
              else           widx_d = widx_q + 1'b1;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      widx_q  <= '0;
      part_q  <= '0;
      fin_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      widx_q  <= widx_d;
      part_q  <= part_d;
      fin_q   <= fin_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader; expected writes come from the
// byte image sliced into little-endian words.
module tb_imem_loader;
  localparam int MW = 256;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RST, Start, Byte_Valid;
  logic [7:0]    Byte_Data;
  logic          Byte_Ready, Mem_WE, Core_Hold, Load_Done, Load_Err;
  logic [AW-1:0] Mem_Addr;
  logic [31:0]   Mem_WData;

  always #5 CLK = ~CLK;

  imem_loader #(.MEM_WORDS(MW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Byte_Valid(Byte_Valid),
    .Byte_Data(Byte_Data), .Byte_Ready(Byte_Ready), .Mem_WE(Mem_WE),
    .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Core_Hold(Core_Hold),
    .Load_Done(Load_Done), .Load_Err(Load_Err)
  );

  int checks = 0;
  int failures = 0;
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  logic [7:0]    img[$];

  always @(negedge CLK) if (Mem_WE === 1'b1) begin
    wa_q.push_back(Mem_Addr);
    wd_q.push_back(Mem_WData);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1; tick(); Start = 1'b0;
  endtask

  // Optional random stall, then present b until accepted; returns #1 after accept edge.
  task automatic send(input logic [7:0] b, input int maxgap);
    int g;
    int guard;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    guard = 0;
    Byte_Valid = 1'b0;
    for (int i = 0; i < g; i++) begin
      Byte_Data = 8'($urandom);
      tick();
    end
    Byte_Valid = 1'b1;
    Byte_Data  = b;
    while (Byte_Ready !== 1'b1 && guard < 50) begin tick(); guard++; end
    if (guard >= 50) begin
      checks++; failures++;
      $error("FAIL send_timeout observed Byte_Ready=%b expected=1", Byte_Ready);
    end
    tick();
    Byte_Valid = 1'b0;
  endtask

  function automatic logic [31:0] exp_word(input int k);
    return {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
  endfunction

  task automatic check_writes(input string tag, input int n);
    chk({tag, "_nwrites"}, wa_q.size(), n);
    for (int k = 0; k < n && k < wa_q.size(); k++) begin
      chk({tag, "_addr"}, 32'(wa_q[k]), k);
      chk({tag, "_data"}, wd_q[k], exp_word(k));
    end
  endtask

  task automatic clear_log();
    img.delete(); wa_q.delete(); wd_q.delete();
  endtask

  // Random image of n words; one stray Start injected mid-data must be ignored.
  task automatic run_load(input int n, input int maxgap);
    logic [15:0] nh;
    logic [7:0]  b;
    nh = 16'(n);
    clear_log();
    pulse_start();
    send(nh[7:0], maxgap);
    send(nh[15:8], maxgap);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      img.push_back(b);
      if (i == 2 * n + 1) pulse_start();
      send(b, maxgap);
    end
    tick();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, Byte_Ready, 0);
    chk({tag, "_we"},    Mem_WE, 0);
    chk({tag, "_addr"},  32'(Mem_Addr), 0);
    chk({tag, "_wdata"}, Mem_WData, 0);
    chk({tag, "_hold"},  Core_Hold, 1);
    chk({tag, "_done"},  Load_Done, 0);
    chk({tag, "_err"},   Load_Err, 0);
  endtask

  initial begin
    logic [7:0] prog [8];
    RST = 1'b1; Start = 1'b0; Byte_Valid = 1'b0; Byte_Data = 8'h00;
    tick(); tick();
    RST = 1'b0;
    chk_reset_outs("reset");

    // Byte_Valid in IDLE is ignored
    Byte_Valid = 1'b1; Byte_Data = 8'hAA;
    tick(); tick();
    Byte_Valid = 1'b0;
    chk("idle_ready", Byte_Ready, 0);

    // Normal two-word load
    prog = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    clear_log();
    pulse_start();
    chk("hdr_ready", Byte_Ready, 1);
    send(8'h02, 0); send(8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      img.push_back(prog[i]);
      send(prog[i], 0);
      if (i == 3) begin
        chk("w0_we", Mem_WE, 1);
        chk("w0_addr", 32'(Mem_Addr), 0);
        chk("w0_data", Mem_WData, 32'h0000_0513);
        chk("w0_ready", Byte_Ready, 1);
      end
    end
    chk("w1_we", Mem_WE, 1);
    chk("w1_addr", 32'(Mem_Addr), 1);
    chk("w1_data", Mem_WData, 32'h0010_0593);
    chk("w1_done_early", Load_Done, 0);
    tick();
    chk("norm_done", Load_Done, 1);
    chk("norm_hold", Core_Hold, 0);
    chk("norm_we_off", Mem_WE, 0);
    chk("norm_addr_hold", 32'(Mem_Addr), 1);
    chk("norm_data_hold", Mem_WData, 32'h0010_0593);
    chk("norm_ready", Byte_Ready, 0);
    check_writes("norm", 2);

    // Illegal count 257
    clear_log();
    pulse_start();
    chk("restart_done_clr", Load_Done, 0);
    chk("restart_hold", Core_Hold, 1);
    send(8'h01, 0); send(8'h01, 0);
    chk("err_flag", Load_Err, 1);
    chk("err_ready", Byte_Ready, 0);
    chk("err_hold", Core_Hold, 1);
    chk("err_done", Load_Done, 0);
    Byte_Valid = 1'b1; tick(); tick(); tick(); Byte_Valid = 1'b0;
    chk("err_nwrites", wa_q.size(), 0);
    chk("err_stays", Load_Err, 1);

    // Zero count
    clear_log();
    pulse_start();
    chk("err_clr", Load_Err, 0);
    send(8'h00, 0); send(8'h00, 0);
    chk("zero_done", Load_Done, 1);
    chk("zero_hold", Core_Hold, 0);
    tick();
    chk("zero_nwrites", wa_q.size(), 0);

    // Full image with random stalls
    run_load(MW, 3);
    check_writes("full", MW);
    chk("full_last_addr", 32'(Mem_Addr), MW - 1);
    chk("full_done", Load_Done, 1);

    // Restart from DONE
    run_load(3, 2);
    check_writes("restart", 3);
    chk("restart_done", Load_Done, 1);

    // Reset after 2 data bytes of word 3
    clear_log();
    pulse_start();
    send(8'h05, 0); send(8'h00, 0);
    for (int i = 0; i < 14; i++) begin
      img.push_back(8'($urandom));
      send(img[i], 1);
    end
    tick();
    RST = 1'b1; Start = 1'b1; Byte_Valid = 1'b1; Byte_Data = 8'h5A;
    tick();
    RST = 1'b0; Start = 1'b0; Byte_Valid = 1'b0;
    chk_reset_outs("midrst");
    tick(); tick();
    check_writes("midrst", 3);
    chk("midrst_idle_ready", Byte_Ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
